sma_order_executor: RTL
=======================

// Module: sma_order_executor
// PURPOSE
//  Consumer end of the SMA strategy's buy_signal/sell_signal interface. Turns one-cycle
//  trade decisions into single-lot orders on a valid/ready order port toward the exchange
//  gateway, waits for the gateway's fill/reject response and tracks the net signed
//  position. Enforces a position limit, a fill timeout and a post-order cooldown.
// PARAMETERS
//  MAX_POS      default 8'd4   max |position| in lots; legal range 1..127
//  FILL_TIMEOUT default 16     cycles to wait in WAIT_FILL before abandoning; >= 1
//  COOLDOWN     default 4      cycles spent in COOLDOWN after each order; >= 1
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  buy_signal   in   1  strategy buy request (level sampled in IDLE)
//  sell_signal  in   1  strategy sell request (level sampled in IDLE)
//  price        in   8  current market price, captured with the request
//  order_valid  out  1  order offered to gateway
//  order_ready  in   1  gateway accepts order when order_valid && order_ready
//  order_side   out  1  1 = buy, 0 = sell
//  order_price  out  8  limit price of the offered order
//  fill_valid   in   1  gateway response strobe
//  fill_ok      in   1  with fill_valid: 1 = filled (1 lot), 0 = rejected
//  position     out  8  signed net position in lots (two's complement)
//  busy         out  1  high in every state except IDLE
//  timeout_err  out  1  one-cycle pulse when a fill timeout occurs
// BEHAVIOUR
//  Reset: state=IDLE; order_valid, order_side, order_price, position, busy,
//   timeout_err and all counters = 0. Reset mid-order abandons the order, no position change.
//  FSM states: IDLE, SEND, WAIT_FILL, COOLDOWN.
//  IDLE: buy_signal && !sell_signal && position < +MAX_POS -> latch side=1, price; go SEND.
//   sell_signal && !buy_signal && position > -MAX_POS -> latch side=0, price; go SEND.
//   Both asserted, or the limit is reached in the requested direction -> stay IDLE, nothing issued.
//  Latency: request sampled at edge N -> order_valid=1 in the cycle after edge N.
//  SEND: order_valid=1; order_side/order_price held stable while !order_ready.
//   Inputs buy/sell/price are ignored. On the valid&&ready edge -> WAIT_FILL, timer cleared,
//   order_valid=0 next cycle. fill_valid in SEND is ignored.
//  WAIT_FILL: timer increments each cycle. fill_valid&&fill_ok -> position +1 (buy) or -1
//   (sell), go COOLDOWN. fill_valid&&!fill_ok -> no change, go COOLDOWN.
//   No fill by the cycle where timer == FILL_TIMEOUT-1 -> timeout_err pulses in the next cycle,
//   go COOLDOWN, position unchanged. If fill_valid arrives in that last cycle, the fill wins
//   (no timeout_err).
//  COOLDOWN: exactly COOLDOWN cycles, then IDLE; signals ignored; fill_valid ignored.
//  fill_valid outside WAIT_FILL is always ignored (stale or duplicate responses).
//  Position changes only by +-1 per fill, so it stays within [-MAX_POS, +MAX_POS]; no overflow.
//  Outputs are registered; position updates in the cycle after the fill edge.
// TESTING
//  1 Reset, then buy_signal=1 for 1 cycle with price=8'd100, order_ready=1 -> order_valid
//    for 1 cycle, side=1, price=100; fill_valid/fill_ok=1 2 cycles later -> position=1,
//    busy low after 4 COOLDOWN cycles.
//  2 Backpressure: order_ready=0 for 5 cycles while price toggles -> order_valid held,
//    order_price constant at the latched value; accepted on cycle 6.
//  3 Limit: five buy/fill sequences with MAX_POS=4 -> position saturates at 4; the 5th
//    buy produces no order_valid; a subsequent sell is accepted -> position=3.
//  4 Timeout: order accepted, no fill for 16 cycles -> timeout_err 1-cycle pulse,
//    position unchanged; a late fill_valid during COOLDOWN is ignored.
//  5 Reject and conflicts: fill_ok=0 leaves position unchanged; buy_signal and sell_signal
//    both asserted in IDLE produce no order.
//  6 Reset asserted in WAIT_FILL -> next cycle all outputs 0, state IDLE, and a subsequent
//    fill_valid is ignored.

Source files
------------

// File: rtl/sma_order_executor.sv
// SMA order executor: turns one-cycle buy/sell decisions into single-lot orders
// on a valid/ready port, waits for the gateway's fill or reject, and tracks the
// signed net position. It also enforces a position limit, a fill timeout and a
// post-order cooldown.
module sma_order_executor #(
  parameter logic [7:0] MAX_POS      = 8'd4,
  parameter int         FILL_TIMEOUT = 16,
  parameter int         COOLDOWN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buy_signal,
  input  logic       sell_signal,
  input  logic [7:0] price,
  output logic       order_valid,
  input  logic       order_ready,
  output logic       order_side,
  output logic [7:0] order_price,
  input  logic       fill_valid,
  input  logic       fill_ok,
  output logic [7:0] position,
  output logic       busy,
  output logic       timeout_err
);

  localparam int TW = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(FILL_TIMEOUT - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN - 1);
  localparam logic signed [7:0] POS_HI = $signed(MAX_POS);
  localparam logic signed [7:0] POS_LO = -$signed(MAX_POS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_FILL,
    S_COOLDOWN
  } state_t;

  state_t            r_state;
  logic [TW-1:0]     r_timer;
  logic [CW-1:0]     r_cool;
  logic signed [7:0] r_position;
  logic              r_order_valid;
  logic              r_order_side;
  logic [7:0]        r_order_price;
  logic              r_busy;
  logic              r_timeout_err;

  logic              w_buy_ok;
  logic              w_sell_ok;

  // Move one lot in the filled direction; the limit check upstream keeps the
  // result inside [-MAX_POS, +MAX_POS], so no saturation is needed here.
  function automatic logic signed [7:0] step_position(input logic signed [7:0] pos,
                                                      input logic              side);
    return side ? (pos + 8'sd1) : (pos - 8'sd1);
  endfunction

  // A request is acted on only if it is unambiguous and stays within the limit.
  always_comb begin
    w_buy_ok  = buy_signal && !sell_signal && (r_position < POS_HI);
    w_sell_ok = sell_signal && !buy_signal && (r_position > POS_LO);
  end

  // Order lifecycle FSM with registered outputs and position tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_cool        <= '0;
      r_position    <= '0;
      r_order_valid <= 1'b0;
      r_order_side  <= 1'b0;
      r_order_price <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_buy_ok || w_sell_ok) begin
            r_state       <= S_SEND;
            r_order_valid <= 1'b1;
            r_order_side  <= w_buy_ok;
            r_order_price <= price;
            r_busy        <= 1'b1;
          end
        end
        S_SEND: begin
          // Side and price stay frozen until the gateway takes the order.
          if (order_ready) begin
            r_state       <= S_WAIT_FILL;
            r_order_valid <= 1'b0;
            r_timer       <= '0;
          end
        end
        S_WAIT_FILL: begin
          // A response in the final timer cycle still counts as a response.
          if (fill_valid) begin
            if (fill_ok) begin
              r_position <= step_position(r_position, r_order_side);
            end
            r_state <= S_COOLDOWN;
            r_cool  <= '0;
          end else if (r_timer == TIMER_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_COOLDOWN;
            r_cool        <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_COOLDOWN: begin
          if (r_cool == COOL_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cool <= r_cool + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign order_valid = r_order_valid;
  assign order_side  = r_order_side;
  assign order_price = r_order_price;
  assign position    = r_position;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule
